// File: rtl/shift_normalizer.sv
// Multi-cycle normaliser: shifts a latched operand one bit per clock toward the
// MSB (left mode) or LSB (right mode) until that bit is 1, reporting the shift count.
module shift_normalizer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             left,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // The zero-operand result reports WIDTH itself, so the count must hold it.
  if (CNT_W < $clog2(WIDTH + 1)) begin : g_cnt_w_check
    $error("shift_normalizer: CNT_W too narrow to hold WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q,  sreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               left_q,  left_d;
  logic [WIDTH-1:0]   dout_q,  dout_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               zero_q,  zero_d;

  logic               target_bit;

  assign target_bit = left_q ? sreg_q[WIDTH-1] : sreg_q[0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb infers a latch.
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    dout_d  = dout_q;
    count_d = count_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = din;
          left_d  = left;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (sreg_q == '0) begin
          dout_d  = '0;
          count_d = CNT_W'(WIDTH);
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (target_bit) begin
          dout_d  = sreg_q;
          count_d = cnt_q;
          zero_d  = 1'b0;
          state_d = DONE;
        end else begin
          // A set bit exists and isn't at the target yet, so cnt_q stays below WIDTH-1 here.
          sreg_d = left_q ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all state, including the result registers, clears on reset so an
      // aborted operation leaves no stale result behind.
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      dout_q  <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      dout_q  <= dout_d;
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign dout  = dout_q;
  assign count = count_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer: latency, results, back-to-back starts
// and asynchronous abort, with hand-computed expectations.
module tb_shift_normalizer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             left;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] count;
  logic             zero;

  int n_checks = 0;
  int n_errors = 0;

  shift_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .left  (left),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .count (count),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and checks latency (negedges after the start edge
  // until done is seen), the result, busy coverage, the single-cycle pulse
  // and that the result holds afterwards. din/left are scrambled mid-operation.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input logic l,
                        input logic [WIDTH-1:0] exp_dout, input int exp_cnt,
                        input logic exp_zero, input int exp_lat);
    int   lat;
    logic busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    din   = d;
    left  = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din   = ~d;
    left  = ~l;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy"},    {31'd0, busy_ok & busy}, 32'd1);
    check({tag, " dout"},    dout, exp_dout);
    check({tag, " count"},   count, exp_cnt);
    check({tag, " zero"},    zero, exp_zero);
    @(negedge clk);
    check({tag, " done_pulse"}, {busy, done}, 2'b00);
    check({tag, " hold"},       {zero, count, dout}, {exp_zero, CNT_W'(exp_cnt), exp_dout});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    left  = 1'b0;
    din   = '0;
    #12;
    check("reset busy",  busy,  0);
    check("reset done",  done,  0);
    check("reset dout",  dout,  0);
    check("reset count", count, 0);
    check("reset zero",  zero,  0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("left_0400",  16'h0400, 1'b1, 16'h8000, 5,  1'b0, 7);
    run_op("right_0A00", 16'h0A00, 1'b0, 16'h0005, 9,  1'b0, 11);
    run_op("zero_left",  16'h0000, 1'b1, 16'h0000, 16, 1'b1, 2);
    run_op("zero_right", 16'h0000, 1'b0, 16'h0000, 16, 1'b1, 2);
    run_op("left_8000",  16'h8000, 1'b1, 16'h8000, 0,  1'b0, 2);
    run_op("right_0001", 16'h0001, 1'b0, 16'h0001, 0,  1'b0, 2);
    run_op("worst_left", 16'h0001, 1'b1, 16'h8000, 15, 1'b0, 17);
    run_op("worst_right",16'h8000, 1'b0, 16'h0001, 15, 1'b0, 17);

    // Back-to-back: start held high; first op 0x0010 left (n=11), din/left
    // changed to 0x0001/right during it, which the second op must pick up.
    @(negedge clk);
    din   = 16'h0010;
    left  = 1'b1;
    start = 1'b1;
    @(negedge clk);  // cycle T+1
    din  = 16'h0001;
    left = 1'b0;
    for (int i = 2; i <= 13; i++) @(negedge clk);
    check("b2b first done",  {busy, done}, 2'b11);
    check("b2b first dout",  dout, 16'h8000);
    check("b2b first count", count, 11);
    @(negedge clk);  // T+14: IDLE, start sampled at the end of this cycle
    check("b2b idle gap",    {busy, done}, 2'b00);
    check("b2b hold dout",   dout, 16'h8000);
    @(negedge clk);  // T+15: SHIFT
    check("b2b second busy", {busy, done}, 2'b10);
    @(negedge clk);  // T+16: DONE
    check("b2b second done", {busy, done}, 2'b11);
    check("b2b second res",  {zero, count, dout}, {1'b0, 5'd0, 16'h0001});
    start = 1'b0;
    @(negedge clk);
    check("b2b back idle",   {busy, done}, 2'b00);

    // Abort: reset asserted during SHIFT clears everything asynchronously.
    @(negedge clk);
    din   = 16'h0001;
    left  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("abort pre busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort outputs", {busy, done, zero, count, dout}, 24'd0);
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (i == 2) rst_n = 1'b1;
        if (done) saw_done = 1'b1;
      end
      check("abort no done", saw_done, 0);
    end
    check("abort cleared", {busy, zero, count, dout}, 23'd0);

    run_op("post_reset", 16'h0A00, 1'b0, 16'h0005, 9, 1'b0, 11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
